// File: rtl/execute_stage_pkg.sv
// ============================================================================
//  Module      : execute_stage_pkg
//  Description : Shared ALU opcodes, multiply/divide op codes and MD FSM states
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package execute_stage_pkg;

    // ALU opcodes (5 bits)
    localparam logic [4:0] C_ALU_ADD  = 5'd0;
    localparam logic [4:0] C_ALU_ADDU = 5'd1;
    localparam logic [4:0] C_ALU_SUB  = 5'd2;
    localparam logic [4:0] C_ALU_SUBU = 5'd3;
    localparam logic [4:0] C_ALU_AND  = 5'd4;
    localparam logic [4:0] C_ALU_OR   = 5'd5;
    localparam logic [4:0] C_ALU_XOR  = 5'd6;
    localparam logic [4:0] C_ALU_NOR  = 5'd7;
    localparam logic [4:0] C_ALU_SLT  = 5'd8;
    localparam logic [4:0] C_ALU_SLTU = 5'd9;
    localparam logic [4:0] C_ALU_SLL  = 5'd10;
    localparam logic [4:0] C_ALU_SRL  = 5'd11;
    localparam logic [4:0] C_ALU_SRA  = 5'd12;
    localparam logic [4:0] C_ALU_SLLV = 5'd13;
    localparam logic [4:0] C_ALU_SRLV = 5'd14;
    localparam logic [4:0] C_ALU_SRAV = 5'd15;
    localparam logic [4:0] C_ALU_LUI  = 5'd16;

    // Multiply/divide op codes (3 bits)
    localparam logic [2:0] C_MD_NONE  = 3'd0;
    localparam logic [2:0] C_MD_MULT  = 3'd1;
    localparam logic [2:0] C_MD_MULTU = 3'd2;
    localparam logic [2:0] C_MD_DIV   = 3'd3;
    localparam logic [2:0] C_MD_DIVU  = 3'd4;
    localparam logic [2:0] C_MD_MFHI  = 3'd5;
    localparam logic [2:0] C_MD_MFLO  = 3'd6;

    // Multiply/divide FSM states
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ITER  = 2'd1;
    localparam logic [1:0] C_ST_FIX   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/execute_stage_muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative HI/LO multiply (shift-add) / divide (restoring) unit
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import execute_stage_pkg::*;
#(
    parameter int W        = 32,
    parameter int MD_ITERS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   i_md_op,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo,
    output logic         o_busy
);

    logic [1:0]     r_state;
    logic [5:0]     r_cnt;
    logic [W-1:0]   r_wk_hi;
    logic [W-1:0]   r_wk_lo;
    logic [W-1:0]   r_divisor;
    logic [W-1:0]   r_dividend;
    logic           r_is_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_div_zero;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_launch;
    logic           w_signed;
    logic           w_is_div;
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [W:0]     w_madd;
    logic [W:0]     w_rem_sh;
    logic [W+1:0]   w_rem_diff;
    logic           w_q_bit;
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;

    assign w_is_div = (i_md_op == C_MD_DIV) || (i_md_op == C_MD_DIVU);
    assign w_signed = (i_md_op == C_MD_MULT) || (i_md_op == C_MD_DIV);
    assign w_launch = (r_state == C_ST_IDLE) &&
                      ((i_md_op == C_MD_MULT) || (i_md_op == C_MD_MULTU) || w_is_div);
    assign w_mag_a  = (w_signed && i_op_a[W-1]) ? -i_op_a : i_op_a;
    assign w_mag_b  = (w_signed && i_op_b[W-1]) ? -i_op_b : i_op_b;

    // Multiply: wk_lo holds the multiplier, product shifts in from the top.
    assign w_madd     = {1'b0, r_wk_hi} + (r_wk_lo[0] ? {1'b0, r_divisor} : '0);
    // Divide: wk_hi is the partial remainder, wk_lo shifts dividend out / quotient in.
    assign w_rem_sh   = {r_wk_hi, r_wk_lo[W-1]};
    assign w_rem_diff = {1'b0, w_rem_sh} - {2'b00, r_divisor};
    assign w_q_bit    = ~w_rem_diff[W+1];

    assign w_prod     = {r_wk_hi, r_wk_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_wk_lo : r_wk_lo;
    assign w_rem_fix  = r_neg_r ? -r_wk_hi : r_wk_hi;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= C_ST_IDLE;
            r_cnt      <= 6'd0;
            r_wk_hi    <= '0;
            r_wk_lo    <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_launch) begin
                        r_state    <= C_ST_ITER;
                        r_cnt      <= 6'd0;
                        r_wk_hi    <= '0;
                        r_wk_lo    <= w_mag_a;
                        r_divisor  <= w_mag_b;
                        r_dividend <= i_op_a;
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_signed & (i_op_a[W-1] ^ i_op_b[W-1]);
                        r_neg_r    <= w_signed & i_op_a[W-1];
                        r_div_zero <= (i_op_b == '0);
                    end
                end
                C_ST_ITER: begin
                    if (r_is_div) begin
                        r_wk_hi <= w_q_bit ? w_rem_diff[W-1:0] : w_rem_sh[W-1:0];
                        r_wk_lo <= {r_wk_lo[W-2:0], w_q_bit};
                    end else begin
                        r_wk_hi <= w_madd[W:1];
                        r_wk_lo <= {w_madd[0], r_wk_lo[W-1:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(MD_ITERS - 1)) begin
                        r_state <= C_ST_FIX;
                    end
                end
                C_ST_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*W-1:W];
                        r_lo <= w_prod_fix[W-1:0];
                    end else if (r_div_zero) begin
                        r_hi <= r_dividend;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_state <= C_ST_IDLE;
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = (r_state != C_ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
//  Module      : execute_stage
//  Description : MIPS EX stage - input regs, ALU, HI/LO muldiv, dependency stall.
//                Optional signed-overflow trap on ADD/SUB: define OVF_TRAP_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int W        = 32,
    parameter int MD_ITERS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   mem_bundle_in,
    input  logic [4:0]   alu_op_in,
    input  logic         alu_src_imm_in,
    input  logic [2:0]   md_op_in,
    input  logic [W-1:0] reg_a_in,
    input  logic [W-1:0] reg_b_in,
    input  logic [W-1:0] imm_in,
    input  logic [4:0]   shamt_in,
    input  logic [4:0]   write_reg_in,
    input  logic [W-1:0] pc_seq_in,
    output logic [7:0]   mem_bundle_out,
    output logic [W-1:0] address_out,
    output logic [W-1:0] reg_b_out,
    output logic [4:0]   write_reg_out,
    output logic [W-1:0] pc_seq_out,
    output logic         stall_out,
    output logic         overflow_out
);

    logic [7:0]   r_mem_bundle;
    logic [4:0]   r_alu_op;
    logic         r_alu_src_imm;
    logic [2:0]   r_md_op;
    logic [W-1:0] r_reg_a;
    logic [W-1:0] r_reg_b;
    logic [W-1:0] r_imm;
    logic [4:0]   r_shamt;
    logic [4:0]   r_write_reg;
    logic [W-1:0] r_pc_seq;

    logic [W-1:0] w_op_b;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_alu;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;
    logic         w_busy;
    logic         w_stall;
    logic         w_ovf;
    logic         w_kill;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mem_bundle  <= '0;
            r_alu_op      <= '0;
            r_alu_src_imm <= 1'b0;
            r_md_op       <= '0;
            r_reg_a       <= '0;
            r_reg_b       <= '0;
            r_imm         <= '0;
            r_shamt       <= '0;
            r_write_reg   <= '0;
            r_pc_seq      <= '0;
        end else if (!w_stall) begin
            r_mem_bundle  <= mem_bundle_in;
            r_alu_op      <= alu_op_in;
            r_alu_src_imm <= alu_src_imm_in;
            r_md_op       <= md_op_in;
            r_reg_a       <= reg_a_in;
            r_reg_b       <= reg_b_in;
            r_imm         <= imm_in;
            r_shamt       <= shamt_in;
            r_write_reg   <= write_reg_in;
            r_pc_seq      <= pc_seq_in;
        end
    end

    muldiv_unit #(
        .W        (W),
        .MD_ITERS (MD_ITERS)
    ) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .i_md_op (r_md_op),
        .i_op_a  (r_reg_a),
        .i_op_b  (r_reg_b),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy)
    );

    assign w_op_b = r_alu_src_imm ? r_imm : r_reg_b;
    assign w_sum  = r_reg_a + w_op_b;
    assign w_diff = r_reg_a - w_op_b;

    // Shifts act on operand B (rt); variable shifts take the amount from rs.
    always_comb begin
        w_alu = '0;
        case (r_alu_op)
            C_ALU_ADD, C_ALU_ADDU: w_alu = w_sum;
            C_ALU_SUB, C_ALU_SUBU: w_alu = w_diff;
            C_ALU_AND:  w_alu = r_reg_a & w_op_b;
            C_ALU_OR:   w_alu = r_reg_a | w_op_b;
            C_ALU_XOR:  w_alu = r_reg_a ^ w_op_b;
            C_ALU_NOR:  w_alu = ~(r_reg_a | w_op_b);
            C_ALU_SLT:  w_alu = {{(W-1){1'b0}}, ($signed(r_reg_a) < $signed(w_op_b))};
            C_ALU_SLTU: w_alu = {{(W-1){1'b0}}, (r_reg_a < w_op_b)};
            C_ALU_SLL:  w_alu = w_op_b << r_shamt;
            C_ALU_SRL:  w_alu = w_op_b >> r_shamt;
            C_ALU_SRA:  w_alu = $unsigned($signed(w_op_b) >>> r_shamt);
            C_ALU_SLLV: w_alu = w_op_b << r_reg_a[4:0];
            C_ALU_SRLV: w_alu = w_op_b >> r_reg_a[4:0];
            C_ALU_SRAV: w_alu = $unsigned($signed(w_op_b) >>> r_reg_a[4:0]);
            C_ALU_LUI:  w_alu = {r_imm[15:0], {(W-16){1'b0}}};
            default:    w_alu = '0;
        endcase
    end

`ifdef OVF_TRAP_EN
    assign w_ovf = ((r_alu_op == C_ALU_ADD) && (r_reg_a[W-1] == w_op_b[W-1]) &&
                    (w_sum[W-1] != r_reg_a[W-1])) ||
                   ((r_alu_op == C_ALU_SUB) && (r_reg_a[W-1] != w_op_b[W-1]) &&
                    (w_diff[W-1] != r_reg_a[W-1]));
`else
    assign w_ovf = 1'b0;
`endif

    // A dependent op waits out the running operation; the stage emits bubbles meanwhile.
    assign w_stall = w_busy && (r_md_op != C_MD_NONE);
    assign w_kill  = w_stall | w_ovf;

    assign address_out    = (r_md_op == C_MD_MFHI) ? w_hi :
                            (r_md_op == C_MD_MFLO) ? w_lo : w_alu;
    assign mem_bundle_out = w_kill ? 8'd0 : r_mem_bundle;
    assign write_reg_out  = w_kill ? 5'd0 : r_write_reg;
    assign reg_b_out      = r_reg_b;
    assign pc_seq_out     = r_pc_seq;
    assign stall_out      = w_stall;
    assign overflow_out   = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Directed self-checking bench for execute_stage
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_bundle_in;
    logic [4:0]  alu_op_in;
    logic        alu_src_imm_in;
    logic [2:0]  md_op_in;
    logic [31:0] reg_a_in;
    logic [31:0] reg_b_in;
    logic [31:0] imm_in;
    logic [4:0]  shamt_in;
    logic [4:0]  write_reg_in;
    logic [31:0] pc_seq_in;
    logic [7:0]  mem_bundle_out;
    logic [31:0] address_out;
    logic [31:0] reg_b_out;
    logic [4:0]  write_reg_out;
    logic [31:0] pc_seq_out;
    logic        stall_out;
    logic        overflow_out;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef OVF_TRAP_EN
    localparam logic [31:0] EXP_ADD_OVF = 32'd1;
    localparam logic [31:0] EXP_ADD_WR  = 32'd0;
    localparam logic [31:0] EXP_ADD_BUN = 32'd0;
`else
    localparam logic [31:0] EXP_ADD_OVF = 32'd0;
    localparam logic [31:0] EXP_ADD_WR  = 32'd3;
    localparam logic [31:0] EXP_ADD_BUN = 32'hA5;
`endif

    always #5 clk = ~clk;

    execute_stage dut (
        .clk            (clk),
        .reset          (reset),
        .mem_bundle_in  (mem_bundle_in),
        .alu_op_in      (alu_op_in),
        .alu_src_imm_in (alu_src_imm_in),
        .md_op_in       (md_op_in),
        .reg_a_in       (reg_a_in),
        .reg_b_in       (reg_b_in),
        .imm_in         (imm_in),
        .shamt_in       (shamt_in),
        .write_reg_in   (write_reg_in),
        .pc_seq_in      (pc_seq_in),
        .mem_bundle_out (mem_bundle_out),
        .address_out    (address_out),
        .reg_b_out      (reg_b_out),
        .write_reg_out  (write_reg_out),
        .pc_seq_out     (pc_seq_out),
        .stall_out      (stall_out),
        .overflow_out   (overflow_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction and advance one clock; outputs are sampled 1 ns later.
    task automatic issue(input logic [4:0] op, input logic src, input logic [2:0] md,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] sh, input logic [4:0] wr, input logic [7:0] bun,
                         input logic [31:0] pc);
        alu_op_in      = op;
        alu_src_imm_in = src;
        md_op_in       = md;
        reg_a_in       = a;
        reg_b_in       = b;
        imm_in         = imm;
        shamt_in       = sh;
        write_reg_in   = wr;
        mem_bundle_in  = bun;
        pc_seq_in      = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(C_ALU_ADDU, 1'b0, C_MD_NONE, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 8'd0, 32'd0);
    endtask

    // Count consecutive stall cycles, bounded so a stuck stall cannot hang the run.
    task automatic wait_stall(output int n);
        n = 0;
        while (stall_out === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int ns;
        logic any_stall;

        reset = 1'b0;
        nop();
        nop();
        chk("rst_addr", address_out, 32'd0);
        chk("rst_bundle", {24'd0, mem_bundle_out}, 32'd0);
        chk("rst_wr", {27'd0, write_reg_out}, 32'd0);
        chk("rst_pc", pc_seq_out, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        reset = 1'b1;

        issue(C_ALU_ADD, 1'b0, C_MD_NONE, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd0, 5'd3, 8'hA5, 32'h100);
        chk("add_res", address_out, 32'h80000000);
        chk("add_ovf", {31'd0, overflow_out}, EXP_ADD_OVF);
        chk("add_wr", {27'd0, write_reg_out}, EXP_ADD_WR);
        chk("add_bundle", {24'd0, mem_bundle_out}, EXP_ADD_BUN);
        chk("add_pc", pc_seq_out, 32'h100);

        issue(C_ALU_ADDU, 1'b1, C_MD_NONE, 32'd5, 32'hDEADBEEF, 32'd7, 5'd0, 5'd2, 8'h11, 32'h104);
        chk("addu_imm", address_out, 32'd12);
        chk("addu_regb", reg_b_out, 32'hDEADBEEF);
        chk("addu_wr", {27'd0, write_reg_out}, 32'd2);

        issue(C_ALU_SUB, 1'b0, C_MD_NONE, 32'd3, 32'd5, 32'd0, 5'd0, 5'd1, 8'h01, 32'h108);
        chk("sub_res", address_out, 32'hFFFFFFFE);
        chk("sub_ovf", {31'd0, overflow_out}, 32'd0);

        issue(C_ALU_SRA, 1'b0, C_MD_NONE, 32'd0, 32'h80000000, 32'd0, 5'd4, 5'd1, 8'h01, 32'h10C);
        chk("sra", address_out, 32'hF8000000);
        issue(C_ALU_SLTU, 1'b0, C_MD_NONE, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd1, 8'h01, 32'h110);
        chk("sltu", address_out, 32'd1);
        issue(C_ALU_SLT, 1'b0, C_MD_NONE, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd1, 8'h01, 32'h114);
        chk("slt", address_out, 32'd0);
        issue(C_ALU_LUI, 1'b1, C_MD_NONE, 32'd0, 32'd0, 32'hFFFF1234, 5'd0, 5'd1, 8'h01, 32'h118);
        chk("lui", address_out, 32'h12340000);
        issue(C_ALU_SRLV, 1'b0, C_MD_NONE, 32'h28, 32'hF0000000, 32'd0, 5'd0, 5'd1, 8'h01, 32'h11C);
        chk("srlv", address_out, 32'h00F00000);
        issue(C_ALU_NOR, 1'b0, C_MD_NONE, 32'd0, 32'hFF, 32'd0, 5'd0, 5'd1, 8'h01, 32'h120);
        chk("nor", address_out, 32'hFFFFFF00);

        // MULT -3*5 followed immediately by dependent MFLO
        issue(C_ALU_ADDU, 1'b0, C_MD_MULT, 32'hFFFFFFFD, 32'd5, 32'd0, 5'd0, 5'd0, 8'h00, 32'h124);
        chk("mult_nostall", {31'd0, stall_out}, 32'd0);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h5A, 32'h128);
        chk("mflo_stall", {31'd0, stall_out}, 32'd1);
        chk("mflo_bubble_wr", {27'd0, write_reg_out}, 32'd0);
        chk("mflo_bubble_bun", {24'd0, mem_bundle_out}, 32'd0);
        wait_stall(ns);
        chk("mult_stall_len", ns, 32'd33);
        chk("mflo_val", address_out, 32'hFFFFFFF1);
        chk("mflo_wr", {27'd0, write_reg_out}, 32'd9);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd8, 8'h5A, 32'h12C);
        chk("mult_hi", address_out, 32'hFFFFFFFF);

        // DIV -7/2
        issue(C_ALU_ADDU, 1'b0, C_MD_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 5'd0, 5'd0, 8'h00, 32'h130);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h134);
        wait_stall(ns);
        chk("div_stall_len", ns, 32'd33);
        chk("div_lo", address_out, 32'hFFFFFFFD);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h138);
        chk("div_hi", address_out, 32'hFFFFFFFF);

        // DIV 0x80000000 / -1
        issue(C_ALU_ADDU, 1'b0, C_MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0, 8'h00, 32'h13C);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h140);
        wait_stall(ns);
        chk("divmin_lo", address_out, 32'h80000000);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h144);
        chk("divmin_hi", address_out, 32'h00000000);

        // DIVU by zero with only independent instructions following
        issue(C_ALU_ADDU, 1'b0, C_MD_DIVU, 32'h1234, 32'd0, 32'd0, 5'd0, 5'd0, 8'h00, 32'h148);
        any_stall = stall_out;
        for (int i = 0; i < 35; i++) begin
            nop();
            any_stall = any_stall | stall_out;
        end
        chk("divu_nostall", {31'd0, any_stall}, 32'd0);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFLO, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h14C);
        chk("divz_lo", address_out, 32'hFFFFFFFF);
        chk("divz_lo_stall", {31'd0, stall_out}, 32'd0);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 8'h01, 32'h150);
        chk("divz_hi", address_out, 32'h00001234);

        // Reset during ITER cycle 10 of a DIV
        issue(C_ALU_ADDU, 1'b0, C_MD_DIV, 32'd100, 32'd7, 32'd0, 5'd0, 5'd0, 8'h00, 32'h154);
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 8'h01, 32'h158);
        chk("rstdiv_stall_before", {31'd0, stall_out}, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstdiv_stall_after", {31'd0, stall_out}, 32'd0);
        reset = 1'b1;
        issue(C_ALU_ADDU, 1'b0, C_MD_MFHI, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 8'h01, 32'h15C);
        chk("rstdiv_hi", address_out, 32'd0);
        chk("rstdiv_nostall", {31'd0, stall_out}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
